// File: rtl/dmi_req_engine_pkg.sv
// Shared DMI types for the DTM request engine: the Debug Module register map,
// DMI op and status encodings, the dmi scan register layout and the
// request-engine FSM states.
package dmi_req_engine_pkg;

  // Debug Module register map as seen on the DMI address bus (7-bit space).
  typedef enum logic [6:0] {
    DATA0        = 7'h04,
    DATA1        = 7'h05,
    DMCONTROL    = 7'h10,
    DMSTATUS     = 7'h11,
    HARTINFO     = 7'h12,
    HALTSUM1     = 7'h13,
    ABSTRACTCS   = 7'h16,
    COMMAND      = 7'h17,
    ABSTRACTAUTO = 7'h18,
    PROGBUF0     = 7'h20,
    SBCS         = 7'h38,
    HALTSUM0     = 7'h40
  } DMI_MMAP;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    SUCCESS = 2'd0,
    FAILED  = 2'd2,
    BUSY    = 2'd3
  } dmi_stat_e;

  // Layout of the dmi scan register: {addr, data, op}.
  typedef struct packed {
    DMI_MMAP     addr;
    logic [31:0] data;
    dmi_op_e     op;
  } dmi_scan_t;

  typedef enum logic {
    IDLE,
    REQ
  } req_state_e;

  // Only reads and writes produce a DMIPort transaction.
  function automatic logic is_xfer_op(dmi_op_e op);
    return (op == READ) || (op == WRITE);
  endfunction

endpackage

// File: rtl/dmi_req_engine_if.sv
// DMIPort: valid/ready request channel from the DTM to the Debug Module.
//   valid    - request present (Master -> Slave)
//   ready    - request accepted this cycle (Slave -> Master)
//   write_en - 1 write, 0 read
//   addr     - Debug Module register address
//   wdata    - write data
//   rdata    - read data, valid in the handshake cycle of a read
interface DMIPort;
  import dmi_req_engine_pkg::*;

  logic        valid;
  logic        ready;
  logic        write_en;
  DMI_MMAP     addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport Master (
    output valid, write_en, addr, wdata,
    input  ready, rdata
  );

  modport Slave (
    input  valid, write_en, addr, wdata,
    output ready, rdata
  );

endinterface

// File: rtl/dmi_req_engine.sv
// DTM back end: turns each Update-DR of the dmi scan register into one
// DMIPort transaction, keeps the sticky op status and builds the value loaded
// into the scan register on Capture-DR.
//   clk, rst        - clock, synchronous active-high reset
//   update_valid    - Update-DR pulse; update_value = {addr, data, op}
//   capture_en      - Capture-DR pulse; capture_value = {addr, data, op}
//   dmireset        - clear sticky status
//   dmihardreset    - abort outstanding request and clear status
//   dmistat         - sticky status for dtmcs
//   busy            - a request is outstanding
//   dmi             - DMIPort master
// ABITS must equal the width of DMI_MMAP (7).
module dmi_req_engine
  import dmi_req_engine_pkg::*;
#(
  parameter int unsigned ABITS   = 7,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             update_valid,
  input  logic [ABITS+33:0] update_value,
  input  logic             capture_en,
  output logic [ABITS+33:0] capture_value,
  input  logic             dmireset,
  input  logic             dmihardreset,
  output logic [1:0]       dmistat,
  output logic             busy,
  DMIPort.Master           dmi
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  dmi_scan_t   upd;
  req_state_e  state_q, state_d;
  dmi_stat_e   stat_q;
  DMI_MMAP     req_addr_q;
  logic        req_we_q;
  logic [31:0] req_wdata_q;
  DMI_MMAP     last_addr_q;
  logic [31:0] last_rdata_q;
  dmi_scan_t   cap_q;
  logic [CW-1:0] cnt_q;

  logic start;
  logic handshake;
  logic timed_out;
  logic busy_evt;

  assign upd = update_value;

  // Next-state and per-cycle events.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    handshake = 1'b0;
    timed_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        start = update_valid && (stat_q == SUCCESS) && is_xfer_op(upd.op);
        if (start) state_d = REQ;
      end
      REQ: begin
        handshake = dmi.ready;
        // A late ready still wins over a timeout in the same cycle.
        timed_out = (TIMEOUT > 0) && !dmi.ready && (cnt_q == TO_LAST);
        if (handshake || timed_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Update or capture while a request is outstanding reports busy.
  assign busy_evt = (state_q == REQ) && (update_valid || capture_en);

  always_ff @(posedge clk) begin
    if (rst || dmihardreset) state_q <= IDLE;
    else                     state_q <= state_d;
  end

  // Sticky status: only moves away from SUCCESS; busy outranks failed.
  always_ff @(posedge clk) begin
    if (rst || dmihardreset) begin
      stat_q <= SUCCESS;
    end else if (dmireset) begin
      stat_q <= SUCCESS;
    end else if (stat_q == SUCCESS) begin
      if (busy_evt)       stat_q <= BUSY;
      else if (timed_out) stat_q <= FAILED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr_q   <= DMI_MMAP'(7'd0);
      req_we_q     <= 1'b0;
      req_wdata_q  <= '0;
      cnt_q        <= '0;
      last_addr_q  <= DMI_MMAP'(7'd0);
      last_rdata_q <= '0;
      cap_q        <= '0;
    end else if (dmihardreset) begin
      // Hard reset clears the bus side only; scan-visible history survives.
      req_addr_q  <= DMI_MMAP'(7'd0);
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      if (start) begin
        req_addr_q  <= upd.addr;
        req_we_q    <= (upd.op == WRITE);
        req_wdata_q <= upd.data;
        last_addr_q <= upd.addr;
        cnt_q       <= '0;
      end else if (state_q == REQ) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (handshake && !req_we_q) last_rdata_q <= dmi.rdata;
      // Uses pre-edge state, so a capture in the handshake cycle reports busy.
      if (capture_en) begin
        cap_q <= '{addr: last_addr_q,
                   data: last_rdata_q,
                   op:   dmi_op_e'((state_q == REQ) ? BUSY : stat_q)};
      end
    end
  end

  assign busy          = (state_q == REQ);
  assign dmistat       = stat_q;
  assign capture_value = cap_q;

  assign dmi.valid    = (state_q == REQ);
  assign dmi.addr     = req_addr_q;
  assign dmi.write_en = req_we_q;
  assign dmi.wdata    = req_wdata_q;

endmodule

// File: tb/tb_dmi_req_engine.sv
module tb_dmi_req_engine;
  import dmi_req_engine_pkg::*;

  localparam int unsigned ABITS   = 7;
  localparam int unsigned TIMEOUT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        update_valid;
  logic [40:0] update_value;
  logic        capture_en;
  logic [40:0] capture_value;
  logic        dmireset;
  logic        dmihardreset;
  logic [1:0]  dmistat;
  logic        busy;

  DMIPort dmi_bus();

  dmi_req_engine #(.ABITS(ABITS), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .update_valid (update_valid),
    .update_value (update_value),
    .capture_en   (capture_en),
    .capture_value(capture_value),
    .dmireset     (dmireset),
    .dmihardreset (dmihardreset),
    .dmistat      (dmistat),
    .busy         (busy),
    .dmi          (dmi_bus)
  );

  int errors = 0;
  int checks = 0;

  // Transaction-level reference: one optional pending request plus history.
  bit          m_req;
  logic [6:0]  m_addr;
  bit          m_we;
  logic [31:0] m_wdata;
  int          m_age;
  int          m_stat;
  logic [6:0]  m_last_addr;
  logic [31:0] m_last_rdata;
  logic [40:0] m_cap;

  function automatic logic [40:0] scan(logic [6:0] a, logic [31:0] d, logic [1:0] op);
    return {a, d, op};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Applies the current inputs to the reference for the coming clock edge.
  function automatic void model_step();
    bit req0, hs, tmo, bevt;
    int stat0;
    logic [1:0] op;
    req0  = m_req;
    stat0 = m_stat;
    if (rst) begin
      m_req = 0; m_addr = '0; m_we = 0; m_wdata = '0; m_age = 0; m_stat = 0;
      m_last_addr = '0; m_last_rdata = '0; m_cap = '0;
      return;
    end
    if (dmihardreset) begin
      m_req = 0; m_addr = '0; m_we = 0; m_wdata = '0; m_stat = 0;
      return;
    end
    if (capture_en) m_cap = {m_last_addr, m_last_rdata, req0 ? 2'd3 : 2'(stat0)};
    hs   = req0 && dmi_bus.ready;
    tmo  = req0 && !dmi_bus.ready && (TIMEOUT != 0) && (m_age + 1 == int'(TIMEOUT));
    bevt = req0 && (update_valid || capture_en);
    if (dmireset) m_stat = 0;
    else if (stat0 == 0) begin
      if (bevt)     m_stat = 3;
      else if (tmo) m_stat = 2;
    end
    if (hs) begin
      if (!m_we) m_last_rdata = dmi_bus.rdata;
      m_req = 0;
    end else if (tmo) begin
      m_req = 0;
    end else if (req0) begin
      m_age++;
    end
    op = update_value[1:0];
    if (!req0 && update_valid && stat0 == 0 && (op == 2'd1 || op == 2'd2)) begin
      m_req       = 1;
      m_age       = 0;
      m_addr      = update_value[40:34];
      m_we        = (op == 2'd2);
      m_wdata     = update_value[33:2];
      m_last_addr = m_addr;
    end
  endfunction

  // One clock: step reference, sample on negedge, compare, clear pulses.
  task automatic tick();
    model_step();
    @(negedge clk);
    chk("valid", 64'(dmi_bus.valid), 64'(m_req));
    chk("busy", 64'(busy), 64'(m_req));
    chk("dmistat", 64'(dmistat), 64'(m_stat));
    chk("capture_value", 64'(capture_value), 64'(m_cap));
    if (m_req) begin
      chk("addr", 64'(dmi_bus.addr), 64'(m_addr));
      chk("write_en", 64'(dmi_bus.write_en), 64'(m_we));
      chk("wdata", 64'(dmi_bus.wdata), 64'(m_wdata));
    end
    rst = 0; update_valid = 0; capture_en = 0; dmireset = 0; dmihardreset = 0;
  endtask

  task automatic upd(logic [6:0] a, logic [31:0] d, logic [1:0] op);
    update_valid = 1;
    update_value = scan(a, d, op);
  endtask

  initial begin
    int vc;
    rst = 1; update_valid = 0; update_value = '0; capture_en = 0;
    dmireset = 0; dmihardreset = 0;
    dmi_bus.ready = 0; dmi_bus.rdata = '0;
    tick();
    rst = 1;
    tick();
    chk("rst_addr", 64'(dmi_bus.addr), 64'd0);
    chk("rst_we", 64'(dmi_bus.write_en), 64'd0);
    chk("rst_wdata", 64'(dmi_bus.wdata), 64'd0);
    chk("rst_cap", 64'(capture_value), 64'd0);

    // Read, ready on the third valid cycle.
    upd(7'h11, 32'h0, 2'd1);
    tick();
    chk("rd_valid", 64'(dmi_bus.valid), 64'd1);
    chk("rd_addr", 64'(dmi_bus.addr), 64'h11);
    chk("rd_we", 64'(dmi_bus.write_en), 64'd0);
    tick();
    dmi_bus.ready = 1; dmi_bus.rdata = 32'h0000_0C82;
    tick();
    chk("rd_done", 64'(dmi_bus.valid), 64'd0);
    dmi_bus.ready = 0;
    capture_en = 1;
    tick();
    chk("rd_cap", 64'(capture_value), 64'(scan(7'h11, 32'h0000_0C82, 2'd0)));

    // Write, ready together with valid.
    upd(7'h10, 32'h8000_0001, 2'd2);
    dmi_bus.ready = 1; dmi_bus.rdata = 32'hFFFF_FFFF;
    tick();
    chk("wr_valid", 64'(dmi_bus.valid), 64'd1);
    chk("wr_we", 64'(dmi_bus.write_en), 64'd1);
    chk("wr_wdata", 64'(dmi_bus.wdata), 64'h8000_0001);
    tick();
    chk("wr_one_cycle", 64'(dmi_bus.valid), 64'd0);
    dmi_bus.ready = 0;
    capture_en = 1;
    tick();
    chk("wr_cap", 64'(capture_value), 64'(scan(7'h10, 32'h0000_0C82, 2'd0)));

    // Update while busy.
    upd(7'h04, 32'h0, 2'd1);
    tick();
    tick();
    upd(7'h05, 32'h1234, 2'd2);
    tick();
    chk("ub_addr", 64'(dmi_bus.addr), 64'h04);
    dmi_bus.ready = 1; dmi_bus.rdata = 32'h0000_0404;
    tick();
    dmi_bus.ready = 0;
    chk("ub_stat", 64'(dmistat), 64'd3);
    upd(7'h06, 32'h0, 2'd1);
    tick();
    chk("ub_ignored", 64'(dmi_bus.valid), 64'd0);
    dmireset = 1;
    tick();
    upd(7'h06, 32'h0, 2'd1);
    tick();
    chk("ub_after_reset", 64'(dmi_bus.valid), 64'd1);
    dmi_bus.ready = 1; dmi_bus.rdata = 32'h0000_0606;
    tick();
    dmi_bus.ready = 0;

    // Capture while busy, and in the handshake cycle.
    upd(7'h07, 32'h0, 2'd1);
    tick();
    capture_en = 1;
    tick();
    chk("cb_op", 64'(capture_value[1:0]), 64'd3);
    chk("cb_stat", 64'(dmistat), 64'd3);
    dmireset = 1;
    tick();
    capture_en = 1; dmi_bus.ready = 1; dmi_bus.rdata = 32'hDEAD_BEEF;
    tick();
    chk("cb_hs_op", 64'(capture_value[1:0]), 64'd3);
    dmi_bus.ready = 0;
    dmireset = 1;
    tick();

    // Timeout after 4 valid cycles.
    upd(7'h09, 32'h0, 2'd1);
    tick();
    vc = 0;
    if (dmi_bus.valid) vc++;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dmi_bus.valid) vc++;
    end
    chk("to_cycles", 64'(vc), 64'd4);
    chk("to_stat", 64'(dmistat), 64'd2);
    chk("to_busy", 64'(busy), 64'd0);
    capture_en = 1;
    tick();
    chk("to_cap", 64'(capture_value), 64'(scan(7'h09, 32'hDEAD_BEEF, 2'd2)));
    dmireset = 1;
    tick();

    // Ready on the last cycle before timeout completes normally.
    upd(7'h0B, 32'h0, 2'd1);
    tick();
    tick(); tick(); tick();
    dmi_bus.ready = 1; dmi_bus.rdata = 32'h0000_0B0B;
    tick();
    dmi_bus.ready = 0;
    chk("to_edge_stat", 64'(dmistat), 64'd0);

    // Hard reset during REQ with a coincident update.
    capture_en = 1;
    tick();
    upd(7'h0A, 32'h0, 2'd1);
    tick();
    upd(7'h0C, 32'h0, 2'd1);
    dmihardreset = 1;
    tick();
    chk("hr_valid", 64'(dmi_bus.valid), 64'd0);
    chk("hr_stat", 64'(dmistat), 64'd0);
    chk("hr_addr", 64'(dmi_bus.addr), 64'd0);
    chk("hr_cap", 64'(capture_value), 64'(scan(7'h0B, 32'h0000_0B0B, 2'd0)));
    tick();
    chk("hr_discard", 64'(dmi_bus.valid), 64'd0);

    // Randomized traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      update_valid  = ($urandom_range(3) == 0);
      update_value  = {7'($urandom), 32'($urandom), 2'($urandom)};
      capture_en    = ($urandom_range(5) == 0);
      dmireset      = ($urandom_range(11) == 0);
      dmihardreset  = ($urandom_range(39) == 0);
      rst           = ($urandom_range(149) == 0);
      if (dmihardreset) capture_en = 0;
      if (dmireset) update_valid = 0;
      dmi_bus.ready = ($urandom_range(2) == 0);
      dmi_bus.rdata = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
